// File: rtl/disp_capture_wr.sv
// Frame-capture writer: packs RGB pixel pairs into 64-bit words, queues them in a word FIFO
// and writes them to the display frame buffer as AXI4 INCR bursts, one burst outstanding at a time.
module disp_capture_wr #(
  parameter int C_BURST_LEN  = 16,
  parameter int C_FIFO_DEPTH = 32
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        CAP_EN,
  input  logic [31:0] CAP_BASE,
  input  logic        VIN_VALID,
  input  logic        VIN_DE,
  input  logic        VIN_HSYNC_X,
  input  logic        VIN_VSYNC_X,
  input  logic [7:0]  VIN_R,
  input  logic [7:0]  VIN_G,
  input  logic [7:0]  VIN_B,
  output logic        CAP_IRQ,
  output logic        CAP_BUSY,
  output logic        CAP_OVER,
  output logic        CAP_BERR,
  output logic [31:0] AWADDR,
  output logic [7:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [63:0] WDATA,
  output logic [7:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam int AW  = $clog2(C_FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int LW  = $clog2(C_BURST_LEN) + 1;
  localparam int OPW = 24 - LW - 3;

  localparam logic [1:0] F_IDLE  = 2'd0;
  localparam logic [1:0] F_CAP   = 2'd1;
  localparam logic [1:0] F_FLUSH = 2'd2;

  localparam logic [1:0] B_IDLE = 2'd0;
  localparam logic [1:0] B_ADDR = 2'd1;
  localparam logic [1:0] B_DATA = 2'd2;
  localparam logic [1:0] B_RESP = 2'd3;

  logic [1:0]    f_q, f_d, b_q, b_d;
  logic [24:0]   base_q, base_d;
  logic [23:0]   off_q, off_d;
  logic          vs_q, vs_d, phase_q, phase_d, push_q, push_d;
  logic [31:0]   lo_q, lo_d;
  logic [63:0]   word_q, word_d;
  logic          over_q, over_d, berr_q, berr_d;
  logic [LW-1:0] len_q, len_d, beat_q, beat_d;

  logic [63:0]   mem_q [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        frame_edge, full, pop, push_ok, drop, flush_done, last_beat;
  logic [31:0] pix;
  logic        unused_sigs;

  assign unused_sigs = ^{VIN_HSYNC_X, CAP_BASE[6:0]};

  assign pix        = {8'h00, VIN_R, VIN_G, VIN_B};
  assign frame_edge = VIN_VALID & vs_q & ~VIN_VSYNC_X;
  assign full       = (cnt_q == CW'(C_FIFO_DEPTH));
  assign pop        = (b_q == B_DATA) & WREADY;
  // A pop in the same cycle frees the slot the incoming word needs.
  assign push_ok    = push_q & (~full | pop);
  assign drop       = push_q & full & ~pop;
  assign flush_done = (f_q == F_FLUSH) & (cnt_q == '0) & ~push_q & (b_q == B_IDLE);
  assign last_beat  = (beat_q == len_q - LW'(1));

  always_comb begin
    f_d     = f_q;
    b_d     = b_q;
    base_d  = base_q;
    off_d   = off_q;
    phase_d = phase_q;
    lo_d    = lo_q;
    word_d  = word_q;
    push_d  = 1'b0;
    over_d  = over_q;
    berr_d  = berr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    vs_d    = VIN_VALID ? VIN_VSYNC_X : vs_q;

    case (f_q)
      F_IDLE: begin
        if (frame_edge && CAP_EN) begin
          base_d  = CAP_BASE[31:7];
          off_d   = '0;
          phase_d = 1'b0;
          over_d  = 1'b0;
          berr_d  = 1'b0;
          f_d     = F_CAP;
        end
      end
      F_CAP: begin
        if (frame_edge) begin
          f_d = F_FLUSH;
        end else if (VIN_VALID && VIN_DE) begin
          if (!phase_q) begin
            lo_d    = pix;
            phase_d = 1'b1;
          end else begin
            word_d  = {pix, lo_q};
            push_d  = 1'b1;
            phase_d = 1'b0;
          end
        end
      end
      F_FLUSH: if (flush_done) f_d = F_IDLE;
      default: f_d = F_IDLE;
    endcase

    if (drop) over_d = 1'b1;

    case (b_q)
      B_IDLE: begin
        if (cnt_q >= CW'(C_BURST_LEN)) begin
          len_d = LW'(C_BURST_LEN);
          b_d   = B_ADDR;
        end else if (f_q == F_FLUSH && cnt_q != '0) begin
          len_d = LW'(cnt_q);
          b_d   = B_ADDR;
        end
      end
      B_ADDR: begin
        if (AWREADY) begin
          off_d  = off_q + {{OPW{1'b0}}, len_q, 3'b000};
          beat_d = '0;
          b_d    = B_DATA;
        end
      end
      B_DATA: begin
        if (WREADY) begin
          beat_d = beat_q + LW'(1);
          if (last_beat) b_d = B_RESP;
        end
      end
      B_RESP: begin
        if (BVALID) begin
          berr_d = berr_q | (BRESP != 2'b00);
          b_d    = B_IDLE;
        end
      end
      default: b_d = B_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      f_q      <= F_IDLE;
      b_q      <= B_IDLE;
      base_q   <= '0;
      off_q    <= '0;
      vs_q     <= 1'b1;
      phase_q  <= 1'b0;
      push_q   <= 1'b0;
      lo_q     <= '0;
      word_q   <= '0;
      over_q   <= 1'b0;
      berr_q   <= 1'b0;
      len_q    <= '0;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      f_q      <= f_d;
      b_q      <= b_d;
      base_q   <= base_d;
      off_q    <= off_d;
      vs_q     <= vs_d;
      phase_q  <= phase_d;
      push_q   <= push_d;
      lo_q     <= lo_d;
      word_q   <= word_d;
      over_q   <= over_d;
      berr_q   <= berr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= word_q;
  end

  // Payload fields are zeroed whenever their valid is low so every output reads 0 in reset.
  assign AWVALID  = (b_q == B_ADDR);
  assign AWADDR   = AWVALID ? ({base_q, 7'b0} + {8'h00, off_q}) : 32'h0;
  assign AWLEN    = AWVALID ? 8'(len_q - LW'(1)) : 8'h00;
  assign AWSIZE   = AWVALID ? 3'b011 : 3'b000;
  assign AWBURST  = AWVALID ? 2'b01 : 2'b00;
  assign WVALID   = (b_q == B_DATA);
  assign WDATA    = WVALID ? mem_q[rd_ptr_q] : 64'h0;
  assign WSTRB    = WVALID ? 8'hFF : 8'h00;
  assign WLAST    = WVALID & last_beat;
  assign BREADY   = (b_q == B_RESP);
  assign CAP_IRQ  = flush_done;
  assign CAP_BUSY = (f_q != F_IDLE);
  assign CAP_OVER = over_q;
  assign CAP_BERR = berr_q;

endmodule

// File: tb/tb_disp_capture_wr.sv
// Directed bench for disp_capture_wr: drives raster frames, models an AXI write slave
// and checks bursts, data, status flags and IRQ against hand-computed expectations.
module tb_disp_capture_wr;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        CAP_EN;
  logic [31:0] CAP_BASE;
  logic        VIN_VALID, VIN_DE, VIN_HSYNC_X, VIN_VSYNC_X;
  logic [7:0]  VIN_R, VIN_G, VIN_B;
  logic        CAP_IRQ, CAP_BUSY, CAP_OVER, CAP_BERR;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;

  disp_capture_wr dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .CAP_EN(CAP_EN), .CAP_BASE(CAP_BASE),
    .VIN_VALID(VIN_VALID), .VIN_DE(VIN_DE), .VIN_HSYNC_X(VIN_HSYNC_X), .VIN_VSYNC_X(VIN_VSYNC_X),
    .VIN_R(VIN_R), .VIN_G(VIN_G), .VIN_B(VIN_B),
    .CAP_IRQ(CAP_IRQ), .CAP_BUSY(CAP_BUSY), .CAP_OVER(CAP_OVER), .CAP_BERR(CAP_BERR),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial forever #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // AXI slave model state and transaction logs
  int aw_delay = 0, aw_wait = 0, w_block = 0, bad_burst = 0;
  int b_cnt = 0, b_at_irq = 0, irq_cnt = 0;
  bit b_pend = 0;
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [63:0] wd_q[$];
  bit          wl_q[$];
  logic [63:0] exp_q[$];

  // Ready/valid are decided at the falling edge, so a handshake seen here completes at the next rise.
  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00; b_pend = 0; aw_wait = 0;
        continue;
      end
      if (b_pend) begin
        BVALID = 1;
        BRESP  = (b_cnt + 1 == bad_burst) ? 2'b10 : 2'b00;
        if (BREADY) begin
          b_cnt++;
          b_pend = 0;
        end
      end else begin
        BVALID = 0;
        BRESP  = 2'b00;
      end
      if (AWVALID) begin
        if (aw_wait >= aw_delay) begin
          AWREADY = 1;
          aw_addr_q.push_back(AWADDR);
          aw_len_q.push_back(AWLEN);
          aw_wait = 0;
        end else begin
          AWREADY = 0;
          aw_wait++;
        end
      end else begin
        AWREADY = 0;
      end
      if (w_block > 0) begin
        WREADY = 0;
        w_block--;
      end else begin
        WREADY = 1;
      end
      if (WVALID && WREADY) begin
        wd_q.push_back(WDATA);
        wl_q.push_back(WLAST);
        if (WLAST) b_pend = 1;
      end
      if (CAP_IRQ) begin
        irq_cnt++;
        b_at_irq = b_cnt;
      end
    end
  end

  // Video driver and expected-word model
  int          pk;
  bit          half;
  logic [23:0] lo_pix;

  task automatic cyc(input bit v, input bit de, input bit vs, input logic [23:0] p);
    @(posedge ACLK);
    #1;
    VIN_VALID = v; VIN_DE = de; VIN_VSYNC_X = vs;
    {VIN_R, VIN_G, VIN_B} = p;
  endtask

  task automatic blank(input int n);
    repeat (n) cyc(1, 0, 1, 24'h0);
  endtask

  task automatic frame_edge();
    cyc(1, 0, 0, 24'h0);
    cyc(1, 0, 1, 24'h0);
  endtask

  task automatic line(input int n, input bit uniq);
    logic [23:0] p;
    logic [7:0]  k8;
    for (int i = 0; i < n; i++) begin
      k8 = pk[7:0];
      p  = uniq ? pk[23:0] : {k8, k8, k8};
      cyc(1, 1, 1, p);
      if (half) exp_q.push_back({8'h00, p, 8'h00, lo_pix});
      else      lo_pix = p;
      half = ~half;
      pk++;
    end
    cyc(1, 0, 1, 24'h0);
  endtask

  task automatic clear_logs();
    aw_addr_q.delete(); aw_len_q.delete(); wd_q.delete(); wl_q.delete(); exp_q.delete();
    pk = 0; half = 0; irq_cnt = 0; b_cnt = 0; b_at_irq = 0;
  endtask

  task automatic wait_irq(input int budget, input string tag);
    int t = 0;
    while (irq_cnt == 0 && t < budget) begin
      @(negedge ACLK);
      t++;
    end
    check_eq(tag, 64'(irq_cnt != 0), 64'd1);
    blank(5);
  endtask

  function automatic logic [31:0] aw_at(input int i);
    return (i < aw_addr_q.size()) ? aw_addr_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [7:0] len_at(input int i);
    return (i < aw_len_q.size()) ? aw_len_q[i] : 8'hEE;
  endfunction

  task automatic cmp_words(input string tag);
    check_eq({tag, "_nwords"}, 64'(wd_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < wd_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), wd_q[i], exp_q[i]);
  endtask

  initial begin
    int bad, prev, beats, nwl;
    logic [31:0] a;
    ARESETN = 0; CAP_EN = 0; CAP_BASE = 32'h0;
    VIN_VALID = 0; VIN_DE = 0; VIN_HSYNC_X = 1; VIN_VSYNC_X = 1;
    VIN_R = 0; VIN_G = 0; VIN_B = 0;
    clear_logs();

    // Reset state
    repeat (3) @(negedge ACLK);
    check_eq("rst_ctl", {AWVALID, WVALID, BREADY, CAP_IRQ, CAP_BUSY, CAP_OVER, CAP_BERR, WLAST}, 8'h00);
    check_eq("rst_aw", {AWADDR, AWLEN, AWSIZE, AWBURST, WSTRB}, 53'h0);
    check_eq("rst_wdata", WDATA, 64'h0);
    ARESETN = 1;
    blank(20);
    check_eq("idle_no_aw", 64'(aw_addr_q.size()), 64'd0);

    // 4 x 32 frame: four full bursts
    clear_logs();
    CAP_BASE = 32'h1000_0000; CAP_EN = 1;
    frame_edge(); blank(2);
    repeat (4) begin line(32, 0); blank(3); end
    frame_edge();
    wait_irq(600, "t2_irq_seen");
    check_eq("t2_naw", 64'(aw_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_addr%0d", i), aw_at(i), 32'h1000_0000 + 32'(i * 128));
      check_eq($sformatf("t2_len%0d", i), len_at(i), 8'd15);
    end
    check_eq("t2_first_wdata", (wd_q.size() > 0) ? wd_q[0] : 64'hX, 64'h00010101_00000000);
    cmp_words("t2");
    check_eq("t2_irq_once", 64'(irq_cnt), 64'd1);
    check_eq("t2_b_before_irq", 64'(b_at_irq), 64'd4);
    check_eq("t2_busy_after", CAP_BUSY, 1'b0);

    // 40-pixel frame: full burst then 4-beat flush burst
    clear_logs();
    CAP_BASE = 32'h2000_0000;
    frame_edge(); blank(2);
    line(40, 0);
    frame_edge();
    wait_irq(300, "t3_irq_seen");
    check_eq("t3_naw", 64'(aw_addr_q.size()), 64'd2);
    check_eq("t3_addr0", aw_at(0), 32'h2000_0000);
    check_eq("t3_len0", len_at(0), 8'd15);
    check_eq("t3_addr1", aw_at(1), 32'h2000_0080);
    check_eq("t3_len1", len_at(1), 8'd3);
    nwl = 0;
    foreach (wl_q[i]) if (wl_q[i]) nwl++;
    check_eq("t3_nwlast", 64'(nwl), 64'd2);
    check_eq("t3_wlast_b1", (wl_q.size() > 15) ? 64'(wl_q[15]) : 64'hX, 64'd1);
    check_eq("t3_wlast_b2", (wl_q.size() > 19) ? 64'(wl_q[19]) : 64'hX, 64'd1);
    cmp_words("t3");
    check_eq("t3_irq_once", 64'(irq_cnt), 64'd1);

    // Backpressure: delayed AWREADY, WREADY low for 200 cycles during a 640-pixel line
    clear_logs();
    CAP_BASE = 32'h4000_0000; aw_delay = 5;
    frame_edge(); blank(2);
    w_block = 200;
    line(640, 1);
    frame_edge();
    wait_irq(3000, "t4_irq_seen");
    aw_delay = 0;
    check_eq("t4_over", CAP_OVER, 1'b1);
    check_eq("t4_some_dropped", 64'(wd_q.size() < 320 && wd_q.size() > 0), 64'd1);
    bad = 0; prev = -1;
    foreach (wd_q[i]) begin
      int lo;
      lo = int'(wd_q[i][23:0]);
      if (lo <= prev || lo[0] || (lo / 2) >= exp_q.size() || wd_q[i] !== exp_q[lo / 2]) bad++;
      prev = lo;
    end
    check_eq("t4_order_nodup", 64'(bad), 64'd0);
    bad = 0; beats = 0; a = 32'h4000_0000;
    foreach (aw_addr_q[i]) begin
      if (aw_addr_q[i] !== a) bad++;
      a = a + 32'((int'(aw_len_q[i]) + 1) * 8);
      beats += int'(aw_len_q[i]) + 1;
    end
    check_eq("t4_addr_seq", 64'(bad), 64'd0);
    check_eq("t4_beats", 64'(beats), 64'(wd_q.size()));
    check_eq("t4_irq_once", 64'(irq_cnt), 64'd1);

    // BRESP error on the 2nd burst; CAP_OVER clears at this frame start
    clear_logs();
    CAP_BASE = 32'h1000_0000; bad_burst = 2;
    frame_edge(); blank(2);
    check_eq("t5_over_clear", CAP_OVER, 1'b0);
    repeat (4) begin line(32, 0); blank(3); end
    frame_edge();
    wait_irq(600, "t5_irq_seen");
    bad_burst = 0;
    check_eq("t5_berr", CAP_BERR, 1'b1);
    check_eq("t5_naw", 64'(aw_addr_q.size()), 64'd4);
    check_eq("t5_b_before_irq", 64'(b_at_irq), 64'd4);
    check_eq("t5_irq_once", 64'(irq_cnt), 64'd1);

    // CAP_EN dropped mid-frame: frame still completes; CAP_BERR clears at start
    clear_logs();
    CAP_BASE = 32'h5000_0000;
    frame_edge(); blank(2);
    check_eq("t5_berr_clear", CAP_BERR, 1'b0);
    line(16, 0);
    CAP_EN = 0;
    line(16, 0);
    frame_edge();
    wait_irq(300, "t6_irq_seen");
    check_eq("t6_naw", 64'(aw_addr_q.size()), 64'd1);
    check_eq("t6_addr0", aw_at(0), 32'h5000_0000);
    cmp_words("t6");

    // CAP_EN=0 at the frame edge: nothing happens
    clear_logs();
    frame_edge(); blank(2);
    line(32, 0);
    frame_edge();
    blank(60);
    check_eq("t6b_no_aw", 64'(aw_addr_q.size()), 64'd0);
    check_eq("t6b_no_irq", 64'(irq_cnt), 64'd0);
    check_eq("t6b_not_busy", CAP_BUSY, 1'b0);

    // Reset during B_DATA of the second burst, then a fresh frame from offset 0
    clear_logs();
    CAP_BASE = 32'h6000_0000; CAP_EN = 1;
    frame_edge(); blank(2);
    line(32, 0);
    begin
      int t = 0;
      while (b_cnt == 0 && t < 200) begin @(negedge ACLK); t++; end
    end
    w_block = 100000;
    line(32, 0);
    begin
      int t = 0;
      while (!WVALID && t < 200) begin @(negedge ACLK); t++; end
    end
    check_eq("t7_wvalid_before", WVALID, 1'b1);
    check_eq("t7_addr1_before", aw_at(1), 32'h6000_0080);
    #2;
    ARESETN = 0;
    #1;
    check_eq("t7_drop_now", {AWVALID, WVALID, BREADY, CAP_BUSY}, 4'b0000);
    repeat (2) @(negedge ACLK);
    w_block = 0;
    #2;
    ARESETN = 1;
    clear_logs();
    frame_edge(); blank(2);
    line(32, 0);
    frame_edge();
    wait_irq(300, "t7_irq_seen");
    check_eq("t7_naw", 64'(aw_addr_q.size()), 64'd1);
    check_eq("t7_addr0_after", aw_at(0), 32'h6000_0000);
    check_eq("t7_len0_after", len_at(0), 8'd15);
    cmp_words("t7");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_capture_wr.md
# disp_capture_wr

Frame-capture writer: the write-side counterpart of the display read path. It accepts a raster pixel stream (R/G/B, DE, HSYNC_X, VSYNC_X), packs pixel pairs into 64-bit frame-buffer words and writes them to DRAM through an AXI4 write-only master. The memory layout is the one the display circuit reads, so a captured frame can be displayed unchanged. It sits beside the display block on the same ACLK/AXI fabric.

## Interface
- C_BURST_LEN, 16: beats per full burst (power of 2, ≤ FIFO depth/2).
- C_FIFO_DEPTH, 32: word FIFO depth (power of 2).

Clock and reset:
- ACLK  in  1  system clock; all signals, including the video input, are synchronous to it.
- ARESETN  in  1  reset, asynchronous and active-low.

Control and status:
- CAP_EN  in  1  capture enable; sampled only at frame start.
- CAP_BASE  in  32  frame base byte address; bits [6:0] ignored (128-byte aligned).
- VIN_VALID  in  1  pixel qualifier; video inputs are meaningful only when it is 1.
- VIN_DE, VIN_HSYNC_X, VIN_VSYNC_X  in  1 each  raster controls (sync active-low). HSYNC_X is unused.
- VIN_R, VIN_G, VIN_B  in  8 each  pixel.
- CAP_IRQ  out  1  one-cycle pulse when a frame is completely written.
- CAP_BUSY  out  1  high while in F_CAP or F_FLUSH.
- CAP_OVER  out  1  sticky; set when a word is dropped because the FIFO is full.
- CAP_BERR  out  1  sticky; set on any BRESP ≠ 2'b00.

AXI4 write master:
- AWADDR 32, AWLEN 8, AWSIZE 3 (=3'b011), AWBURST 2 (=2'b01), AWVALID out; AWREADY in.
- WDATA 64, WSTRB 8 (=8'hFF), WLAST, WVALID out; WREADY in.
- BRESP 2 in, BVALID in, BREADY out.

## Operation
- Frame edge: VIN_VSYNC_X 1→0 on VIN_VALID cycles.
- Frame FSM (F_IDLE, F_CAP, F_FLUSH):
  - F_IDLE: on a frame edge with CAP_EN=1, latch CAP_BASE, clear the offset, pixel phase, CAP_OVER and CAP_BERR, then go to F_CAP.
  - F_CAP: on the next frame edge, go to F_FLUSH.
  - F_FLUSH: wait until the FIFO is empty and the burst FSM is idle, pulse CAP_IRQ, then go to F_IDLE. Frame edges are ignored in F_FLUSH, so the earliest next capture starts at the following edge.
- Deasserting CAP_EN mid-frame has no effect until the next frame start.
- Packing, in F_CAP only, on VIN_VALID & VIN_DE:
  - Even pixel goes to the low half: {8'h00,R0,G0,B0} in [31:0].
  - Odd pixel goes to the high half: {8'h00,R1,G1,B1} in [63:32]; the completed word is then pushed.
  - A dangling even pixel at frame end is discarded.
- Push with the FIFO full: the word is dropped and CAP_OVER is set.
- Burst FSM (B_IDLE, B_ADDR, B_DATA, B_RESP):
  - B_IDLE → B_ADDR when count ≥ C_BURST_LEN, or when in F_FLUSH with count > 0. Burst length n = min(count, C_BURST_LEN).
  - B_ADDR: AWVALID=1, AWADDR = base + offset, AWLEN = n−1. On handshake, offset += 8n, then go to B_DATA.
  - B_DATA: WVALID=1 with WDATA = FIFO head; pop on WREADY. WLAST is asserted on beat n. After the last beat, go to B_RESP.
  - B_RESP: BREADY=1. On BVALID, OR (BRESP≠0) into CAP_BERR, then go to B_IDLE.
- At most one burst is outstanding.
- 4 KB boundaries: bursts of 128 bytes or fewer starting from a 128-byte-aligned base never cross one.
- Offset width is 24 bits and wraps modulo 2^24.

## Timing
- Reset values: every output is 0, including AWVALID, WVALID, BREADY, CAP_IRQ and the status flags. Both FSMs start idle and the FIFO is empty.
- ARESETN low mid-burst aborts the burst immediately; no completion is required.
- Push happens the cycle after the odd pixel is sampled.
- AWVALID rises the cycle after the count reaches the threshold. It is held with AWADDR/AWLEN stable until AWREADY.
- WVALID rises the cycle after the AW handshake. It is held with stable data until WREADY. Throughput is 1 beat/cycle while WREADY=1.
- A push and a pop in the same cycle leave the count unchanged. A pop frees space for a push in the same cycle.
- CAP_IRQ fires the cycle after the final BVALID&BREADY of the frame, or at most 2 cycles after the frame edge if nothing was pending.

## Test plan
- Reset: hold ARESETN=0 → all outputs 0. Release and drive no stimulus → no AXI activity.
- CAP_BASE=0x1000_0000, frame of 4 lines × 32 pixels, pixel k = {k,k,k} → 4 bursts at 0x1000_0000, …_0080, …_0100, …_0180, each AWLEN=15. First WDATA = 64'h00010101_00000000. Exactly one CAP_IRQ, after the 4th B response.
- Flush: 40-pixel frame → burst AWLEN=15 at base, then burst AWLEN=3 at base+0x80, WLAST on its 4th beat, then CAP_IRQ.
- Backpressure: AWREADY delayed 5 cycles and WREADY held low for 200 cycles during a 640-pixel line → CAP_OVER=1. Written words are in order with no duplicates. CAP_OVER clears at the next frame start.
- BRESP=2'b10 on the 2nd burst → CAP_BERR=1 and the frame still completes with CAP_IRQ. CAP_BERR clears at the next frame start.
- CAP_EN=0 at the frame edge → no AW transactions and no IRQ. CAP_EN dropped mid-frame → the frame completes normally.
- ARESETN pulsed low during B_DATA → AWVALID/WVALID drop immediately. The next enabled frame starts at offset 0.
